// File: rtl/vram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_slot_arbiter
// Purpose  : Dot-clock TDM arbiter for one single-port VRAM. Video fetch owns
//            slots 0/1 of each cell; the CPU takes every other slot via
//            req/ack. Optional stall counter: define VRAM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vram_slot_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int SLOT_BITS  = 3
) (
    input  logic                  dot_clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic                  vid_en,
    input  logic [ADDR_WIDTH-1:0] vid_addr_a,
    input  logic [ADDR_WIDTH-1:0] vid_addr_b,
    output logic [DATA_WIDTH-1:0] vid_data_a,
    output logic [DATA_WIDTH-1:0] vid_data_b,
    output logic                  vid_valid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]           stall_count
);

    typedef enum logic [2:0] {
        TAG_NONE   = 3'd0,
        TAG_VA     = 3'd1,
        TAG_VB     = 3'd2,
        TAG_CPU_RD = 3'd3,
        TAG_CPU_WR = 3'd4
    } tag_t;

    localparam logic [SLOT_BITS-1:0] SLOT_ONE = SLOT_BITS'(1);

    logic [SLOT_BITS-1:0]  slot_q, slot_d, cur_slot;
    tag_t                  tag1_q, tag1_d, tag2_q;
    logic                  busy_q, busy_d, cpu_grant;
    logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] vid_data_a_q, vid_data_b_q, cpu_rdata_q;
    logic                  vid_valid_q, cpu_ack_q;
    logic                  tag2_is_cpu;

    assign tag2_is_cpu = (tag2_q == TAG_CPU_RD) || (tag2_q == TAG_CPU_WR);

    always_comb begin
        // The line_start cycle itself acts as slot 0 of the new line.
        cur_slot    = line_start ? '0 : slot_q;
        slot_d      = line_start ? SLOT_ONE : slot_q + SLOT_ONE;
        tag1_d      = TAG_NONE;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_grant   = 1'b0;

        if (vid_en && cur_slot == '0) begin
            tag1_d     = TAG_VA;
            mem_en_d   = 1'b1;
            mem_addr_d = vid_addr_a;
        end else if (vid_en && cur_slot == SLOT_ONE) begin
            tag1_d     = TAG_VB;
            mem_en_d   = 1'b1;
            mem_addr_d = vid_addr_b;
        end else if (cpu_req && !busy_q && !cpu_ack_q) begin
            cpu_grant  = 1'b1;
            tag1_d     = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
            mem_en_d   = 1'b1;
            mem_we_d   = cpu_we;
            mem_addr_d = cpu_addr;
            if (cpu_we) begin
                mem_wdata_d = cpu_wdata;
            end
        end

        busy_d = busy_q;
        if (tag2_is_cpu) begin
            busy_d = 1'b0;
        end
        if (cpu_grant) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            slot_q       <= '0;
            tag1_q       <= TAG_NONE;
            tag2_q       <= TAG_NONE;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            vid_data_a_q <= '0;
            vid_data_b_q <= '0;
            cpu_rdata_q  <= '0;
            vid_valid_q  <= 1'b0;
            cpu_ack_q    <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            // tag2 lines up with the cycle in which mem_rdata is valid.
            vid_valid_q <= (tag2_q == TAG_VB);
            cpu_ack_q   <= tag2_is_cpu;
            if (tag2_q == TAG_VA) begin
                vid_data_a_q <= mem_rdata;
            end
            if (tag2_q == TAG_VB) begin
                vid_data_b_q <= mem_rdata;
            end
            if (tag2_q == TAG_CPU_RD) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (cpu_req && !busy_q && !cpu_ack_q && !cpu_grant &&
                     stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 16'h0000;
`endif

    assign vid_data_a = vid_data_a_q;
    assign vid_data_b = vid_data_b_q;
    assign vid_valid  = vid_valid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_slot_arbiter
// Purpose  : Randomized bench for vram_slot_arbiter against a slot/latency
//            reference model and a shadow copy of VRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_slot_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int EV_NONE = 0;
    localparam int EV_VA   = 1;
    localparam int EV_VB   = 2;
    localparam int EV_RD   = 3;
    localparam int EV_WR   = 4;

    logic dot_clk = 1'b0;
    always #5 dot_clk = ~dot_clk;

    logic          reset, line_start, vid_en, cpu_req, cpu_we;
    logic          vid_valid, cpu_ack, mem_en, mem_we;
    logic [AW-1:0] vid_addr_a, vid_addr_b, cpu_addr, mem_addr;
    logic [DW-1:0] vid_data_a, vid_data_b, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
    logic [15:0]   stall_count;

    vram_slot_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLOT_BITS(3)) dut (
        .dot_clk(dot_clk), .reset(reset), .line_start(line_start), .vid_en(vid_en),
        .vid_addr_a(vid_addr_a), .vid_addr_b(vid_addr_b),
        .vid_data_a(vid_data_a), .vid_data_b(vid_data_b), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_count(stall_count)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 16'h0010) return 8'h41;
        if (i == 16'h0800) return 8'h3C;
        return 8'(i * 7 + 3);
    endfunction

    // Synchronous single-port RAM, read data one cycle after the address.
    logic [DW-1:0] ram [0:65535];
    initial for (int i = 0; i < 65536; i++) ram[i] <= init_val(i);
    always @(posedge dot_clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    logic [DW-1:0] shadow [0:65535];
    int            n_checks = 0;
    int            n_pass   = 0;

    // Reference model: position within the cell, time of last CPU grant and
    // a small calendar of completions due three cycles after each decision.
    int            cyc, pos, last_grant, mode;
    int            ev_type [8];
    logic [DW-1:0] ev_data [8];
    logic          p_en, p_we, p_stall, ls_done, wr_next;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic          exp_en, exp_we, exp_valid, exp_ack;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_va, exp_vb, exp_rdata;
    logic [15:0]   exp_stall;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) ev_type[i] = EV_NONE;
        pos = 0; last_grant = cyc - 100;
        p_en = 0; p_we = 0; p_stall = 0; p_addr = '0; p_wdata = '0;
        exp_en = 0; exp_we = 0; exp_valid = 0; exp_ack = 0;
        exp_addr = '0; exp_wdata = '0; exp_va = '0; exp_vb = '0; exp_rdata = '0;
        exp_stall = '0;
    endtask

    function automatic logic [AW-1:0] pick_vaddr();
        case ($urandom_range(0, 3))
            0: return 16'h0010;
            1: return 16'h0800;
            default: return 16'h1230 + 16'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic new_op();
        cpu_req = 1'b1;
        if (mode == 0) begin
            cpu_we = wr_next; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
            wr_next = ~wr_next;
        end else begin
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = (mode == 2) ? pick_vaddr() : 16'h1230 + 16'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
        end
    endtask

    task automatic drive();
        line_start = 1'b0;
        if (mode == 0) begin
            vid_en = 1'b1; vid_addr_a = 16'h0010; vid_addr_b = 16'h0800;
            if (!ls_done && pos % 8 == 5 && cyc - last_grant <= 2) begin
                line_start = 1'b1; ls_done = 1'b1;
            end
        end else if (mode == 1) begin
            vid_en = 1'b0;
        end else begin
            if ($urandom_range(0, 5) == 0) vid_en = ~vid_en;
            vid_addr_a = pick_vaddr(); vid_addr_b = pick_vaddr();
            if ($urandom_range(0, 29) == 0) line_start = 1'b1;
        end
        if (cpu_req && cpu_ack) begin
            if (mode < 2 || $urandom_range(0, 2) != 0) new_op();
            else cpu_req = 1'b0;
        end else if (!cpu_req) begin
            if (mode < 2 || $urandom_range(0, 3) == 0) new_op();
        end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
            cpu_addr = pick_vaddr(); cpu_wdata = 8'($urandom);
        end
    endtask

    task automatic decide();
        int s;
        int due;
        logic eligible;
        s = line_start ? 0 : pos % 8;
        due = (cyc + 3) % 8;
        eligible = (cyc - last_grant) >= 4;
        p_en = 0; p_we = 0; p_stall = 0;
        if (vid_en && s <= 1) begin
            p_en = 1;
            p_addr = (s == 0) ? vid_addr_a : vid_addr_b;
            ev_type[due] = (s == 0) ? EV_VA : EV_VB;
            ev_data[due] = shadow[p_addr];
            p_stall = cpu_req && eligible;
        end else if (cpu_req && eligible) begin
            last_grant = cyc;
            p_en = 1; p_we = cpu_we; p_addr = cpu_addr;
            if (cpu_we) begin
                p_wdata = cpu_wdata;
                shadow[cpu_addr] = cpu_wdata;
                ev_type[due] = EV_WR;
            end else begin
                ev_type[due] = EV_RD;
                ev_data[due] = shadow[cpu_addr];
            end
        end
        pos = line_start ? 1 : pos + 1;
        cyc++;
    endtask

    task automatic advance();
        int k;
        k = cyc % 8;
        exp_en = p_en; exp_we = p_we;
        if (p_en) exp_addr = p_addr;
        if (p_en && p_we) exp_wdata = p_wdata;
`ifdef VRAM_ARB_STATS_EN
        if (p_stall && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
`endif
        exp_valid = 0; exp_ack = 0;
        case (ev_type[k])
            EV_VA: exp_va = ev_data[k];
            EV_VB: begin exp_vb = ev_data[k]; exp_valid = 1; end
            EV_RD: begin exp_rdata = ev_data[k]; exp_ack = 1; end
            EV_WR: exp_ack = 1;
            default: ;
        endcase
        ev_type[k] = EV_NONE;
    endtask

    task automatic check_all();
        check("mem_en",    16'(mem_en),     16'(exp_en));
        check("mem_we",    16'(mem_we),     16'(exp_we));
        check("mem_addr",  mem_addr,        exp_addr);
        check("mem_wdata", 16'(mem_wdata),  16'(exp_wdata));
        check("vid_a",     16'(vid_data_a), 16'(exp_va));
        check("vid_b",     16'(vid_data_b), 16'(exp_vb));
        check("vid_valid", 16'(vid_valid),  16'(exp_valid));
        check("cpu_ack",   16'(cpu_ack),    16'(exp_ack));
        check("cpu_rdata", 16'(cpu_rdata),  16'(exp_rdata));
        check("stall",     stall_count,     exp_stall);
    endtask

    task automatic step();
        drive();
        decide();
        @(posedge dot_clk); #1;
        advance();
        check_all();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge dot_clk); #1;
            check("rst_mem_en", 16'(mem_en), 16'h0);
        end
        check("rst_ack",   16'(cpu_ack),   16'h0);
        check("rst_valid", 16'(vid_valid), 16'h0);
        check("rst_addr",  mem_addr,       16'h0);
        check("rst_vid_b", 16'(vid_data_b), 16'h0);
        check("rst_stall", stall_count,    16'h0);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) shadow[i] = init_val(i);
        cyc = 0; mode = 0; ls_done = 0; wr_next = 1;
        reset = 1; line_start = 0; vid_en = 1;
        vid_addr_a = 16'h0010; vid_addr_b = 16'h0800;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; cpu_wdata = 8'h00;
        model_clear();
        do_reset(3);
        repeat (80) step();
        mode = 1;
        repeat (120) step();
        mode = 2;
        repeat (1200) step();
        cpu_req = 1;
        do_reset(2);
        repeat (1200) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
